// File: rtl/flag_pkg.sv
// Shared condition-flag definitions for the flag register and its checkpoint stack.
package flag_pkg;
    localparam int FLAG_N     = 0;
    localparam int FLAG_Z     = 1;
    localparam int FLAG_V     = 2;
    localparam int FLAG_C     = 3;
    localparam int NF_DEFAULT = 4;
endpackage

// File: rtl/flag_ckpt_stack.sv
// LIFO of flag snapshots taken at branch issue; storage is not reset, only the count is.
module flag_ckpt_stack
    import flag_pkg::*;
#(
    parameter int NF    = NF_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [NF-1:0]                push_data,
    output logic [NF-1:0]                top_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NF-1:0] mem_q [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] wr_idx, top_idx;
    logic          push_ok, pop_ok;

    always_comb begin
        full    = (count_q == CW'(DEPTH));
        empty   = (count_q == '0);
        push_ok = push && !pop && !full;
        pop_ok  = pop && !empty;
        count_d = count_q;
        if (pop_ok)
            count_d = count_q - CW'(1);
        else if (push_ok)
            count_d = count_q + CW'(1);
        // Top index is meaningless when empty; callers only consume it when count > 0.
        wr_idx  = IW'(count_q);
        top_idx = IW'(count_q - CW'(1));
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok)
            mem_q[wr_idx] <= push_data;
    end

    assign top_data = mem_q[top_idx];
    assign count    = count_q;
endmodule

// File: rtl/flag_ckpt_unit.sv
// Architectural condition-flag register with write bypass and branch checkpoint/restore.
module flag_ckpt_unit
    import flag_pkg::*;
#(
    parameter int NF    = NF_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [NF-1:0]                wr_mask,
    input  logic [NF-1:0]                wr_flags,
    input  logic                         ckpt_push,
    input  logic                         ckpt_pop,
    input  logic                         ckpt_restore,
    output logic [NF-1:0]                flags_q,
    output logic [NF-1:0]                flags_fwd,
    output logic [$clog2(DEPTH+1)-1:0]   ckpt_count,
    output logic                         ckpt_full,
    output logic                         ckpt_empty,
    output logic                         ckpt_err
);
    logic [NF-1:0] top_data, mask_eff, write_merge;
    logic          push_acc, pop_acc, rest_acc;
    logic          multi_cmd, empty_err, full_err;
    logic          err_q, err_d;

    always_comb begin
        mask_eff    = wr_en ? wr_mask : '0;
        write_merge = (wr_flags & mask_eff) | (flags_q & ~mask_eff);

        // Only the highest-priority asserted command may execute; an ignored one does nothing.
        rest_acc = ckpt_restore && !ckpt_empty;
        pop_acc  = ckpt_pop && !ckpt_restore && !ckpt_empty;
        push_acc = ckpt_push && !ckpt_restore && !ckpt_pop && !ckpt_full;

        multi_cmd = (ckpt_push && ckpt_pop) || (ckpt_push && ckpt_restore) ||
                    (ckpt_pop && ckpt_restore);
        empty_err = (ckpt_restore || ckpt_pop) && ckpt_empty;
        full_err  = ckpt_push && !ckpt_restore && !ckpt_pop && ckpt_full;
        err_d     = err_q || multi_cmd || empty_err || full_err;

        flags_fwd = rest_acc ? top_data : write_merge;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_fwd;
            err_q   <= err_d;
        end
    end

    flag_ckpt_stack #(
        .NF    (NF),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push_acc),
        .pop       (pop_acc || rest_acc),
        .push_data (flags_fwd),
        .top_data  (top_data),
        .count     (ckpt_count),
        .full      (ckpt_full),
        .empty     (ckpt_empty)
    );

    assign ckpt_err = err_q;
endmodule

// File: tb/tb_flag_ckpt_unit.sv
// Directed and random checks of flag_ckpt_unit against a queue-based reference model.
module tb_flag_ckpt_unit;
    localparam int NF    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [NF-1:0] wr_mask, wr_flags;
    logic          ckpt_push, ckpt_pop, ckpt_restore;
    logic [NF-1:0] flags_q, flags_fwd;
    logic [2:0]    ckpt_count;
    logic          ckpt_full, ckpt_empty, ckpt_err;

    flag_ckpt_unit #(.NF(NF), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_mask      (wr_mask),
        .wr_flags     (wr_flags),
        .ckpt_push    (ckpt_push),
        .ckpt_pop     (ckpt_pop),
        .ckpt_restore (ckpt_restore),
        .flags_q      (flags_q),
        .flags_fwd    (flags_fwd),
        .ckpt_count   (ckpt_count),
        .ckpt_full    (ckpt_full),
        .ckpt_empty   (ckpt_empty),
        .ckpt_err     (ckpt_err)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_mis = 0;
    logic [3:0]  m_flags;
    logic        m_err;
    logic [3:0]  m_stack[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_flags_q"}, 32'(flags_q), 32'(m_flags));
        chk({tag, "_count"},   32'(ckpt_count), 32'(m_stack.size()));
        chk({tag, "_full"},    32'(ckpt_full), 32'(m_stack.size() == DEPTH));
        chk({tag, "_empty"},   32'(ckpt_empty), 32'(m_stack.size() == 0));
        chk({tag, "_err"},     32'(ckpt_err), 32'(m_err));
    endtask

    // One clock of normal operation: checks the bypass before the edge and the state after it.
    task automatic step(input string tag, input logic we, input logic [3:0] m, input logic [3:0] wf,
                        input logic pu, input logic po, input logic re);
        logic [3:0] exp_fwd;
        int         ncmd;
        rst = 1'b0; wr_en = we; wr_mask = m; wr_flags = wf;
        ckpt_push = pu; ckpt_pop = po; ckpt_restore = re;
        exp_fwd = we ? ((wf & m) | (m_flags & ~m)) : m_flags;
        if (re && m_stack.size() > 0)
            exp_fwd = m_stack[$];
        #1;
        chk({tag, "_fwd"}, 32'(flags_fwd), 32'(exp_fwd));
        @(posedge clk);
        ncmd = int'(pu) + int'(po) + int'(re);
        if (ncmd > 1) m_err = 1'b1;
        if (re) begin
            if (m_stack.size() == 0) m_err = 1'b1;
            else void'(m_stack.pop_back());
        end else if (po) begin
            if (m_stack.size() == 0) m_err = 1'b1;
            else void'(m_stack.pop_back());
        end else if (pu) begin
            if (m_stack.size() == DEPTH) m_err = 1'b1;
            else m_stack.push_back(exp_fwd);
        end
        m_flags = exp_fwd;
        #1;
        chk_state(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        wr_en = 1'($urandom); wr_mask = 4'($urandom); wr_flags = 4'($urandom);
        ckpt_push = 1'($urandom); ckpt_pop = 1'($urandom); ckpt_restore = 1'($urandom);
        @(posedge clk);
        m_flags = '0; m_err = 1'b0; m_stack.delete();
        #1;
        chk_state(tag);
    endtask

    initial begin
        logic [3:0] m, wf;
        logic       we, pu, po, re;
        int         r;

        do_reset("rst0");

        step("w1010", 1'b1, 4'b1111, 4'b1010, 1'b0, 1'b0, 1'b0);
        chk("req032_q", 32'(flags_q), 32'h a);
        step("wmask", 1'b1, 4'b0001, 4'b0101, 1'b0, 1'b0, 1'b0);
        chk("req033_q", 32'(flags_q), 32'h b);

        step("clr", 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
        step("push_w", 1'b1, 4'b1111, 4'b0110, 1'b1, 1'b0, 1'b0);
        chk("req034_cnt1", 32'(ckpt_count), 32'd1);
        step("w1111", 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);
        step("restore", 1'b1, 4'b1001, 4'b1001, 1'b0, 1'b0, 1'b1);
        chk("req034_q", 32'(flags_q), 32'h6);

        for (int i = 0; i < 5; i++)
            step("push5", 1'b1, 4'b0100, 4'(i), 1'b1, 1'b0, 1'b0);
        chk("req035_full", 32'(ckpt_full), 32'd1);
        for (int i = 0; i < 4; i++)
            step("pop4", 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0);
        chk("req035_empty", 32'(ckpt_empty), 32'd1);

        do_reset("rst1");
        step("rest_empty", 1'b1, 4'b1111, 4'b0011, 1'b0, 1'b0, 1'b1);
        chk("req036_q", 32'(flags_q), 32'h3);

        do_reset("rst2");
        step("pA", 1'b1, 4'b1111, 4'b1100, 1'b1, 1'b0, 1'b0);
        step("pB", 1'b1, 4'b1111, 4'b0011, 1'b1, 1'b0, 1'b0);
        step("push_rest", 1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1);
        chk("req037_q", 32'(flags_q), 32'h3);
        do_reset("rst3");

        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset("rnd_rst");
            end else begin
                we = 1'($urandom); m = 4'($urandom); wf = 4'($urandom);
                pu = 1'b0; po = 1'b0; re = 1'b0;
                r = int'($urandom_range(0, 19));
                if (r <= 5) pu = 1'b1;
                else if (r <= 8) po = 1'b1;
                else if (r <= 11) re = 1'b1;
                else if (r == 12) begin
                    pu = 1'($urandom); po = 1'($urandom); re = 1'($urandom);
                end
                step("rnd", we, m, wf, pu, po, re);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/flag_ckpt_unit.md
FLAG_CKPT_UNIT -- requirements
Module: flag_ckpt_unit

Interface
REQ-001 SHALL have parameter NF, default 4, meaning number of condition-flag bits (NF >= 4).
REQ-002 SHALL have parameter DEPTH, default 4, meaning checkpoint stack entries (DEPTH >= 1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  flag write request from ALU.
REQ-006 SHALL have port wr_mask  input  NF  per-bit write enable; bit i updated only if wr_en & wr_mask[i].
REQ-007 SHALL have port wr_flags  input  NF  new flag values; bit0 N, bit1 Z, bit2 V, bit3 C, bits 4+ spare.
REQ-008 SHALL have port ckpt_push  input  1  save current effective flags onto stack (branch issue).
REQ-009 SHALL have port ckpt_pop  input  1  discard top entry, flags unchanged (branch resolved correct).
REQ-010 SHALL have port ckpt_restore  input  1  pop top entry into flag register (mispredict recovery).
REQ-011 SHALL have port flags_q  output  NF  registered architectural flags.
REQ-012 SHALL have port flags_fwd  output  NF  combinational next-flag value (bypass).
REQ-013 SHALL have port ckpt_count  output  $clog2(DEPTH+1)  valid stack entries.
REQ-014 SHALL have ports ckpt_full, ckpt_empty  output  1 each  count==DEPTH, count==0.
REQ-015 SHALL have port ckpt_err  output  1  sticky protocol-error flag.

Function
REQ-016 flags_fwd SHALL equal, per bit i, wr_flags[i] if wr_en & wr_mask[i], else flags_q[i], when no accepted restore; flags_fwd SHALL equal the stack top when a restore is accepted.
REQ-017 flags_q SHALL load flags_fwd on every rising clk edge (zero-latency bypass; no inverted clock).
REQ-018 Command priority SHALL be restore > pop > push; only the highest asserted command executes.
REQ-019 Asserting more than one of push/pop/restore in a cycle SHALL set ckpt_err.
REQ-020 Accepted push SHALL store flags_fwd of that cycle (same-cycle write included) at index count, count+1.
REQ-021 Accepted pop SHALL decrement count; flags_q follows write path only.
REQ-022 Accepted restore SHALL decrement count and drop any same-cycle write (wr_en ignored).
REQ-023 Push when full SHALL be ignored (stack unchanged) and set ckpt_err.
REQ-024 Pop or restore when empty SHALL be ignored, set ckpt_err; wr_en SHALL still apply.
REQ-025 ckpt_err SHALL remain 1 until rst.
REQ-026 count SHALL never wrap; range 0..DEPTH.

Reset
REQ-027 On rst at rising edge: flags_q=0, ckpt_count=0, ckpt_empty=1, ckpt_full=0, ckpt_err=0; all inputs ignored that cycle.
REQ-028 Stack storage SHALL not be reset; entries at index >= count are never observable.
REQ-029 rst mid-speculation SHALL discard all checkpoints with no restore.

Structure
REQ-030 Shared package flag_pkg SHALL hold FLAG_N=0, FLAG_Z=1, FLAG_V=2, FLAG_C=3 and NF_DEFAULT=4.
REQ-031 Stack storage, count, full/empty SHALL live in sub-module flag_ckpt_stack (params NF, DEPTH); top-level holds flag register, bypass mux, priority, error logic.

Verification
REQ-032 Reset then wr_en=1, mask=4'b1111, wr_flags=4'b1010 -> flags_fwd=1010 same cycle, flags_q=1010 next cycle.
REQ-033 flags_q=1010, wr_en=1, mask=4'b0001, wr_flags=4'b0101 -> flags_q=1011.
REQ-034 flags_q=0000, push with same-cycle write 0110; write 1111; restore -> flags_q=0110, count 1->0.
REQ-035 DEPTH=4: five pushes -> count=4, full=1, ckpt_err=1 after fifth; four pops -> empty=1, flags_q unchanged.
REQ-036 Empty stack, restore with wr_en=1, mask=1111, wr_flags=0011 -> flags_q=0011, ckpt_err=1, count=0.
REQ-037 count=2, push+restore same cycle -> restore executes, count=1, ckpt_err=1; then rst -> all outputs at reset values.
